// File: rtl/cia_bus_ctrl.sv
// CIA host-bus access sequencer: oversamples the 6502-style bus and turns
// each phi2 cycle into at most one register read-commit or write strobe.
module cia_bus_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 3,
    parameter int HOLD_CYC    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       phi2,
    input  logic       cs_n,
    input  logic       r_w_n,
    input  logic [3:0] addr,
    input  logic [7:0] data_i,
    input  logic [7:0] rdata,
    output logic [3:0] reg_addr,
    output logic       reg_rd,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic [7:0] data_o,
    output logic       data_oe,
    output logic       phi2_rise,
    output logic       phi2_fall
);

    localparam int MAX_CYC = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int BW      = 15;

    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC);

    typedef enum logic [1:0] {
        LOW,
        SETTLE,
        HIGH,
        HOLD
    } state_t;

    logic [SYNC_STAGES-1:0][BW-1:0] sync_q;
    logic [SYNC_STAGES:0]           fill;

    logic       phi2_s;
    logic       cs_n_s;
    logic       r_w_n_s;
    logic [3:0] addr_s;
    logic [7:0] data_s;
    logic       phi2_d;
    logic       edge_ok;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sel;
    logic          rd;
    logic [7:0]    wdata;

    // All bus inputs share one chain so they stay cycle-aligned with phi2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill   <= '0;
            phi2_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0],
                       {phi2, cs_n, r_w_n, addr, data_i}};
            fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
            phi2_d <= phi2_s;
        end
    end

    assign {phi2_s, cs_n_s, r_w_n_s, addr_s, data_s} = sync_q[SYNC_STAGES-1];

    // Edges are ignored until both phi2_s and phi2_d hold real samples,
    // so a phi2 already high at reset release is not seen as a rise.
    assign edge_ok   = fill[SYNC_STAGES];
    assign phi2_rise = edge_ok & phi2_s & ~phi2_d;
    assign phi2_fall = edge_ok & ~phi2_s & phi2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOW;
            cnt       <= '0;
            sel       <= 1'b0;
            rd        <= 1'b0;
            wdata     <= '0;
            reg_addr  <= '0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            data_o    <= '0;
            data_oe   <= 1'b0;
        end else begin
            reg_rd <= 1'b0;
            reg_wr <= 1'b0;
            unique case (state)
                LOW: begin
                    data_oe <= 1'b0;
                    if (phi2_rise) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LD;
                    end
                end
                SETTLE: begin
                    if (phi2_fall) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state    <= HIGH;
                        sel      <= ~cs_n_s;
                        rd       <= r_w_n_s;
                        reg_addr <= addr_s;
                        data_oe  <= ~cs_n_s & r_w_n_s;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (phi2_fall) begin
                        reg_rd <= sel & rd;
                        reg_wr <= sel & ~rd;
                        if (sel & ~rd)
                            reg_wdata <= wdata;
                        if (HOLD_CYC == 0) begin
                            state   <= LOW;
                            data_oe <= 1'b0;
                        end else begin
                            state <= HOLD;
                            cnt   <= HOLD_LD;
                        end
                    end else begin
                        if (sel & rd)
                            data_o <= rdata;
                        if (sel & ~rd & phi2_s)
                            wdata <= data_s;
                    end
                end
                HOLD: begin
                    if (phi2_rise) begin
                        data_oe <= 1'b0;
                        state   <= SETTLE;
                        cnt     <= SETTLE_LD;
                    end else if (cnt <= CW'(1)) begin
                        data_oe <= 1'b0;
                        state   <= LOW;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_cia_bus_ctrl.sv
// Self-checking bench for cia_bus_ctrl: strobes are scored against a queue
// of expected accesses; timing and boundary cases are checked per task.
module tb_cia_bus_ctrl;

    localparam int SYNC   = 2;
    localparam int SETTLE = 3;
    localparam int HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       phi2;
    logic       cs_n;
    logic       r_w_n;
    logic [3:0] addr;
    logic [7:0] data_i;
    logic [7:0] rdata;
    logic [3:0] reg_addr;
    logic       reg_rd;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic [7:0] data_o;
    logic       data_oe;
    logic       phi2_rise;
    logic       phi2_fall;

    logic [7:0] rf [16];

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise   = 0;
    int n_fall   = 0;
    int n_oe     = 0;
    int n_rd     = 0;
    int n_wr     = 0;

    exp_t        e;
    logic [13:0] got;
    logic [13:0] want;

    always #5 clk = ~clk;

    assign rdata = rf[reg_addr];

    cia_bus_ctrl #(
        .SYNC_STAGES(SYNC),
        .SETTLE_CYC (SETTLE),
        .HOLD_CYC   (HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .phi2     (phi2),
        .cs_n     (cs_n),
        .r_w_n    (r_w_n),
        .addr     (addr),
        .data_i   (data_i),
        .rdata    (rdata),
        .reg_addr (reg_addr),
        .reg_rd   (reg_rd),
        .reg_wr   (reg_wr),
        .reg_wdata(reg_wdata),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .phi2_rise(phi2_rise),
        .phi2_fall(phi2_fall)
    );

    // Monitor: counts events and scores every strobe against the queue.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (phi2_rise) n_rise++;
            if (phi2_fall) n_fall++;
            if (data_oe)   n_oe++;
            if (reg_rd)    n_rd++;
            if (reg_wr)    n_wr++;
            if (reg_rd || reg_wr) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL strobe_unexpected: rd=%0b wr=%0b addr=%h, none expected",
                             reg_rd, reg_wr, reg_addr);
                end else begin
                    e    = sb.pop_front();
                    got  = {reg_rd, reg_wr, reg_addr,
                            reg_wr ? reg_wdata : data_o};
                    want = {~e.wr, e.wr, e.addr, e.data};
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL strobe_content: got rd/wr/addr/data=%h, want %h",
                                 got, want);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        phi2   = 1'b0;
        cs_n   = 1'b1;
        r_w_n  = 1'b1;
        addr   = 4'h0;
        data_i = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({reg_rd, reg_wr, data_oe} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b, want 000",
                     {reg_rd, reg_wr, data_oe});
        end
        n_checks++;
        if ({reg_addr, reg_wdata, data_o} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h, want 00000",
                     {reg_addr, reg_wdata, data_o});
        end
        n_checks++;
        if ({phi2_rise, phi2_fall} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_edges: got %b, want 00",
                     {phi2_rise, phi2_fall});
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write();
        int oe0;
        int rd0;
        oe0    = n_oe;
        rd0    = n_rd;
        cs_n   = 1'b0;
        r_w_n  = 1'b0;
        addr   = 4'hD;
        data_i = 8'h7E;
        sb.push_back(exp_t'{1'b1, 4'hD, 8'h81});
        phi2 = 1'b1;
        repeat (10) @(negedge clk);
        data_i = 8'h81;
        repeat (10) @(negedge clk);
        phi2   = 1'b0;
        data_i = 8'h00;
        repeat (SYNC) @(posedge clk);
        #1;
        n_checks++;
        if (reg_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_early: got %b, want 0", reg_wr);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (reg_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_latency: got %b, want 1", reg_wr);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if ((n_oe - oe0) != 0 || (n_rd - rd0) != 0) begin
            n_fail++;
            $display("FAIL wr_side_effects: got oe=%0d rd=%0d, want 0 0",
                     n_oe - oe0, n_rd - rd0);
        end
    endtask

    task automatic test_read();
        cs_n  = 1'b0;
        r_w_n = 1'b1;
        addr  = 4'h4;
        sb.push_back(exp_t'{1'b0, 4'h4, 8'h5A});
        phi2 = 1'b1;
        repeat (SYNC + SETTLE) @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_early: got %b, want 0", data_oe);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL oe_latency: got %b, want 1", data_oe);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data_o !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_data: got %h, want 5a", data_o);
        end
        repeat (12) @(negedge clk);
        phi2 = 1'b0;
        cs_n = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        n_checks++;
        if (reg_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_latency: got %b, want 1", reg_rd);
        end
        repeat (HOLD - 1) @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL oe_hold: got %b, want 1", data_oe);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_release: got %b, want 0", data_oe);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_deselect();
        int r0, f0, rd0, wr0, oe0;
        r0    = n_rise;
        f0    = n_fall;
        rd0   = n_rd;
        wr0   = n_wr;
        oe0   = n_oe;
        cs_n  = 1'b1;
        r_w_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 4'(i + 3);
            phi2 = 1'b1;
            repeat (8) @(negedge clk);
            phi2 = 1'b0;
            repeat (8) @(negedge clk);
        end
        n_checks++;
        if ((n_rise - r0) != 4 || (n_fall - f0) != 4) begin
            n_fail++;
            $display("FAIL desel_edges: got rise=%0d fall=%0d, want 4 4",
                     n_rise - r0, n_fall - f0);
        end
        n_checks++;
        if ((n_rd - rd0) != 0 || (n_wr - wr0) != 0 || (n_oe - oe0) != 0) begin
            n_fail++;
            $display("FAIL desel_access: got rd=%0d wr=%0d oe=%0d, want 0 0 0",
                     n_rd - rd0, n_wr - wr0, n_oe - oe0);
        end
    endtask

    task automatic test_late_change();
        cs_n  = 1'b0;
        r_w_n = 1'b1;
        addr  = 4'h2;
        sb.push_back(exp_t'{1'b0, 4'h2, 8'h3C});
        phi2 = 1'b1;
        repeat (10) @(negedge clk);
        cs_n  = 1'b1;
        r_w_n = 1'b0;
        addr  = 4'h9;
        repeat (10) @(negedge clk);
        n_checks++;
        if (reg_addr !== 4'h2) begin
            n_fail++;
            $display("FAIL late_addr: got %h, want 2", reg_addr);
        end
        phi2 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int rd0;
        rd0   = n_rd;
        cs_n  = 1'b0;
        r_w_n = 1'b1;
        addr  = 4'h4;
        sb.push_back(exp_t'{1'b0, 4'h4, 8'h5A});
        sb.push_back(exp_t'{1'b0, 4'h7, 8'hC3});
        phi2 = 1'b1;
        repeat (10) @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
        phi2 = 1'b1;
        addr = 4'h7;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_new_cycle: got oe=%b, want 0", data_oe);
        end
        repeat (10) @(negedge clk);
        phi2 = 1'b0;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if ((n_rd - rd0) != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d reads, want 2", n_rd - rd0);
        end
    endtask

    task automatic test_short_phase();
        int r0, f0, rd0, wr0, oe0;
        r0    = n_rise;
        f0    = n_fall;
        rd0   = n_rd;
        wr0   = n_wr;
        oe0   = n_oe;
        cs_n  = 1'b0;
        r_w_n = 1'b1;
        addr  = 4'h4;
        phi2  = 1'b1;
        repeat (SETTLE - 1) @(negedge clk);
        phi2 = 1'b0;
        repeat (10) @(negedge clk);
        cs_n = 1'b1;
        n_checks++;
        if ((n_rd - rd0) != 0 || (n_wr - wr0) != 0 || (n_oe - oe0) != 0) begin
            n_fail++;
            $display("FAIL short_access: got rd=%0d wr=%0d oe=%0d, want 0 0 0",
                     n_rd - rd0, n_wr - wr0, n_oe - oe0);
        end
        n_checks++;
        if ((n_rise - r0) != 1 || (n_fall - f0) != 1) begin
            n_fail++;
            $display("FAIL short_edges: got rise=%0d fall=%0d, want 1 1",
                     n_rise - r0, n_fall - f0);
        end
    endtask

    task automatic test_reset_mid();
        int r0, rd0, wr0;
        cs_n   = 1'b0;
        r_w_n  = 1'b0;
        addr   = 4'h6;
        data_i = 8'h42;
        phi2   = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({reg_addr, reg_wdata, data_o, reg_rd, reg_wr, data_oe} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h, want 000000",
                     {reg_addr, reg_wdata, data_o, reg_rd, reg_wr, data_oe});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0    = n_rise;
        rd0   = n_rd;
        wr0   = n_wr;
        repeat (10) @(negedge clk);
        phi2 = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ((n_rise - r0) != 0 || (n_rd - rd0) != 0 || (n_wr - wr0) != 0) begin
            n_fail++;
            $display("FAIL reset_partial: got rise=%0d rd=%0d wr=%0d, want 0 0 0",
                     n_rise - r0, n_rd - rd0, n_wr - wr0);
        end
        sb.push_back(exp_t'{1'b1, 4'h6, 8'h42});
        phi2 = 1'b1;
        repeat (12) @(negedge clk);
        phi2 = 1'b0;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if ((n_wr - wr0) != 1) begin
            n_fail++;
            $display("FAIL reset_next_cycle: got %0d writes, want 1", n_wr - wr0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            rf[i] = 8'(i * 17);
        rf[2] = 8'h3C;
        rf[4] = 8'h5A;
        rf[7] = 8'hC3;

        test_reset();
        test_write();
        test_read();
        test_deselect();
        test_late_change();
        test_back_to_back();
        test_short_phase();
        test_reset_mid();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cia_bus_ctrl.md
Name: cia_bus_ctrl

Overview:
- Host-bus access sequencer for the CIA register file. Oversamples the asynchronous 6502-style bus (phi2, cs_n, r_w_n, addr, data) with the fast FPGA clock.
- Detects phi2 edges and decides per phi2 cycle whether a register access occurs. Issues single-cycle read-commit and write strobes to the register file and controls the data-bus output enable.
- Also emits phi2 edge ticks, which the timers, TOD and serial logic use as their count enable.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied identically to phi2 and all bus inputs (min 2)
SETTLE_CYC, 3, clk cycles after detected phi2 rise before cs_n/r_w_n/addr are sampled (min 1)
HOLD_CYC, 2, clk cycles data_oe stays asserted after detected phi2 fall (min 0)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
phi2  in  1  raw bus phase-2 clock, asynchronous to clk
cs_n  in  1  raw chip select, active low
r_w_n  in  1  raw read/write; 1 = read
addr  in  4  raw register address
data_i  in  8  raw data bus input
rdata  in  8  register-file read data for reg_addr (combinational in register file)
reg_addr  out  4  latched access address
reg_rd  out  1  one-cycle read-commit pulse (clear-on-read side effects)
reg_wr  out  1  one-cycle write pulse
reg_wdata  out  8  write data, valid while reg_wr=1
data_o  out  8  data bus output value
data_oe  out  1  data bus output enable
phi2_rise  out  1  one-cycle pulse on synchronized phi2 rise
phi2_fall  out  1  one-cycle pulse on synchronized phi2 fall

Behaviour:
- Reset values: all outputs 0, state LOW, counters 0. Reset is asynchronous, so assertion clears everything immediately, including a strobe in the same cycle.
- Input alignment:
  - phi2, cs_n, r_w_n, addr and data_i each pass through a SYNC_STAGES flop chain. All are then "_s" signals with equal latency.
  - phi2_d = phi2_s delayed 1 clk. phi2_rise = phi2_s & ~phi2_d; phi2_fall = ~phi2_s & phi2_d.
- FSM states: LOW, SETTLE, HIGH, HOLD.
  - LOW: waits for phi2_rise, then goes to SETTLE and loads the counter with SETTLE_CYC-1.
  - SETTLE: counter decrements each clk. At 0, goes to HIGH and latches sel = ~cs_n_s, rd = r_w_n_s, reg_addr = addr_s.
    - phi2_fall during SETTLE (short phase) aborts to LOW: no strobes, data_oe stays 0.
  - HIGH, read (sel & rd): data_oe=1 from the first HIGH cycle. data_o = rdata, registered every clk.
  - HIGH, write (sel & ~rd): wdata register loads data_s every clk while phi2_s=1. On fall it holds the last high-phase value.
  - HIGH, exit on phi2_fall:
    - read access: reg_rd=1 for exactly that cycle; data_o is frozen.
    - write access: reg_wr=1 for exactly that cycle, reg_wdata = held wdata.
    - Next state: HOLD with counter = HOLD_CYC, or LOW if HOLD_CYC=0 (data_oe clears in that case).
  - HOLD: data_oe keeps its value and the counter decrements. At 0, data_oe=0 and state goes to LOW.
    - phi2_rise while in HOLD clears data_oe and goes directly to SETTLE. A new cycle always wins.
- Decision is fixed at the sample point. cs_n, r_w_n or addr changing later in HIGH has no effect on that cycle.
- Non-selected cycle (sel=0): no strobes, data_oe=0. phi2_rise and phi2_fall are still emitted.
- reg_rd and reg_wr are mutually exclusive. At most one strobe per phi2 cycle.
- After rst_n deasserts with phi2 already high: the FSM stays in LOW until a full rise is seen. No access occurs in the partial cycle.
- Total access latency, raw phi2 fall to strobe: SYNC_STAGES+1 clk.
- Counter width: $clog2(max(SETTLE_CYC,HOLD_CYC)+1).

Test Plan:
- Write: phi2 high 20 clk, cs_n=0, r_w_n=0, addr=4'hD, data_i=8'h81 -> exactly one reg_wr pulse SYNC_STAGES+1 clk after phi2 fall, reg_addr=4'hD, reg_wdata=8'h81; reg_rd and data_oe stay 0.
- Read: cs_n=0, r_w_n=1, addr=4'h4, rdata=8'h5A -> data_oe rises SYNC_STAGES+1+SETTLE_CYC clk after phi2 rise; data_o=8'h5A; one reg_rd pulse at fall; data_oe drops HOLD_CYC clk after that pulse.
- Deselected: cs_n=1 for 4 phi2 cycles -> 4 phi2_rise and 4 phi2_fall pulses, zero reg_rd/reg_wr, data_oe never 1.
- Late change: cs_n=0 read at sample point, cs_n=1 and addr changed mid-HIGH -> access still completes with the original addr and one reg_rd.
- Short phase: phi2 high only SETTLE_CYC-1 clk after sync -> FSM aborts to LOW, no strobes, data_oe=0.
- Reset: assert rst_n mid-HIGH of a write -> all outputs 0 immediately, no reg_wr; release with phi2 high -> no access until the next full rise/fall.
